// File: rtl/mem_ctrl_hs_if.sv
// rtl/mem_ctrl_hs_if.sv - strobe/ready data-memory bus between mem_ctrl_hs and memory
interface mem_ctrl_hs_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_as_;
    logic              mem_rw;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;
    logic              mem_rdy;

    modport master (
        output mem_addr, mem_as_, mem_rw, mem_be, mem_wr_data,
        input  mem_rd_data, mem_rdy
    );

    modport slave (
        input  mem_addr, mem_as_, mem_rw, mem_be, mem_wr_data,
        output mem_rd_data, mem_rdy
    );
endinterface

// File: rtl/mem_ctrl_hs.sv
// rtl/mem_ctrl_hs.sv - multi-cycle load/store stage controller with strobe/ready memory handshake
module mem_ctrl_hs #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              ex_en,
    input  logic [3:0]        ex_mem_op,
    input  logic [31:0]       ex_mem_wr_data,
    input  logic [ADDR_W-1:0] ex_out,
    output logic              stall,
    output logic [31:0]       out,
    output logic              out_valid,
    output logic              miss_align,
    output logic              bus_err,
    mem_ctrl_hs_if.master     mem
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [1:0]       off_q;

    logic        is_load, is_store, is_byte, is_half, is_word;
    logic        misal, accept;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (ex_mem_op)
            OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase
    end

    assign misal  = (is_half && ex_out[0]) || (is_word && (ex_out[1:0] != 2'b00));
    assign accept = (state == S_IDLE) && ex_en && (is_load || is_store);
    assign stall  = (state == S_BUS) || (accept && !misal);

    // Store lanes are replicated so the memory can pick any lane by byte enable alone.
    always_comb begin
        be_n = 4'hF;
        wd_n = 32'h0;
        if (is_store) begin
            if (is_byte) begin
                be_n = 4'b0001 << ex_out[1:0];
                wd_n = {4{ex_mem_wr_data[7:0]}};
            end else if (is_half) begin
                be_n = 4'b0011 << ex_out[1:0];
                wd_n = {2{ex_mem_wr_data[15:0]}};
            end else begin
                wd_n = ex_mem_wr_data;
            end
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem.mem_rd_data[7:0];
            2'd1:    byte_sel = mem.mem_rd_data[15:8];
            2'd2:    byte_sel = mem.mem_rd_data[23:16];
            default: byte_sel = mem.mem_rd_data[31:24];
        endcase
        half_sel = off_q[1] ? mem.mem_rd_data[31:16] : mem.mem_rd_data[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h0, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0, half_sel};
            default: load_val = mem.mem_rd_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state           <= S_IDLE;
            cnt             <= '0;
            op_q            <= 4'h0;
            off_q           <= 2'b00;
            mem.mem_as_     <= 1'b1;
            mem.mem_rw      <= 1'b1;
            mem.mem_be      <= 4'h0;
            mem.mem_addr    <= '0;
            mem.mem_wr_data <= 32'h0;
            out             <= 32'h0;
            out_valid       <= 1'b0;
            miss_align      <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            miss_align <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (misal) begin
                            miss_align <= 1'b1;
                        end else begin
                            state           <= S_BUS;
                            cnt             <= '0;
                            op_q            <= ex_mem_op;
                            off_q           <= ex_out[1:0];
                            mem.mem_as_     <= 1'b0;
                            mem.mem_rw      <= is_load;
                            mem.mem_be      <= be_n;
                            mem.mem_addr    <= ex_out[ADDR_W-1:2];
                            mem.mem_wr_data <= wd_n;
                        end
                    end
                end
                S_BUS: begin
                    if (mem.mem_rdy) begin
                        state       <= S_DONE;
                        mem.mem_as_ <= 1'b1;
                        out_valid   <= 1'b1;
                        if (mem.mem_rw) out <= load_val;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        state       <= S_DONE;
                        mem.mem_as_ <= 1'b1;
                        bus_err     <= 1'b1;
                        out         <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // DONE always returns to IDLE so the still-held EX request is not re-issued.
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
